// File: rtl/rs_seq_pkg.sv
// Shared constants for the RS latch sequencer: FSM encodings, grant codes and
// default timing parameters.
package rs_seq_pkg;

   localparam int SETUP_CYC_DEF = 1;
   localparam int PULSE_CYC_DEF = 4;
   localparam int DB_CYC_DEF    = 16;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_SETUP = 3'd1;
   localparam state_t ST_PULSE = 3'd2;
   localparam state_t ST_HOLD  = 3'd3;
   localparam state_t ST_CHECK = 3'd4;

   localparam logic GRANT_SET = 1'b0;
   localparam logic GRANT_RST = 1'b1;

endpackage

// File: rtl/sw_sync_debounce.sv
// Switch conditioning: 2-flop synchronizer, optional debouncer (RS_SEQ_DEBOUNCE_EN)
// and a single-cycle rising-edge pulse.
module sw_sync_debounce
   import rs_seq_pkg::*;
#(
   parameter int DB_CYC = DB_CYC_DEF
) (
   input  logic clk,
   input  logic resetn,
   input  logic sw,
   output logic rise
);

   if (DB_CYC < 2 || DB_CYC > 255) begin : g_db_range
      $error("DB_CYC out of range");
   end

   logic [1:0] sync;
   logic [1:0] fill;
   logic       armed;
   logic       lvl;
   logic       lvl_d;

   // A switch already high out of reset must be seen low before any edge counts,
   // so arming waits until the synchronizer holds a real post-reset sample.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync  <= '0;
         fill  <= '0;
         armed <= 1'b0;
         lvl_d <= 1'b0;
      end else begin
         sync  <= {sync[0], sw};
         fill  <= {fill[0], 1'b1};
         armed <= armed | (fill[1] & ~sync[1]);
         lvl_d <= lvl;
      end
   end

`ifdef RS_SEQ_DEBOUNCE_EN
   logic [7:0] db_cnt;
   logic       db_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         db_cnt <= '0;
         db_q   <= 1'b0;
      end else if (sync[1] == db_q) begin
         db_cnt <= '0;
      end else if (db_cnt == 8'(DB_CYC - 1)) begin
         db_q   <= sync[1];
         db_cnt <= '0;
      end else begin
         db_cnt <= db_cnt + 8'd1;
      end
   end

   assign lvl = db_q;
`else
   assign lvl = sync[1];
`endif

   assign rise = lvl & ~lvl_d & armed;

endmodule

// File: rtl/rs_latch_sequencer.sv
// Sequences set/reset operations on an external level-triggered RS latch and
// verifies Q afterwards. Optional switch debouncing via RS_SEQ_DEBOUNCE_EN.
module rs_latch_sequencer
   import rs_seq_pkg::*;
#(
   parameter int SETUP_CYC = SETUP_CYC_DEF,
   parameter int PULSE_CYC = PULSE_CYC_DEF,
   parameter int DB_CYC    = DB_CYC_DEF
) (
   input  logic clk,
   input  logic resetn,
   input  logic sw_set_req,
   input  logic sw_rst_req,
   input  logic latch_q,
   output logic latch_clk,
   output logic latch_s,
   output logic latch_r,
   output logic busy,
   output logic last_grant,
   output logic led_err
);

   if (SETUP_CYC < 1 || SETUP_CYC > 15 || PULSE_CYC < 1 || PULSE_CYC > 15) begin : g_cyc_range
      $error("SETUP_CYC/PULSE_CYC out of range");
   end

   state_t     state;
   state_t     state_nxt;
   logic [3:0] phase;
   logic       set_pend;
   logic       rst_pend;
   logic       set_rise;
   logic       rst_rise;
   logic       grant;
   logic       gnt_sel;
   logic       op_nxt;
   logic       drive_nxt;

   sw_sync_debounce #(.DB_CYC(DB_CYC)) u_set_sw (
      .clk    (clk),
      .resetn (resetn),
      .sw     (sw_set_req),
      .rise   (set_rise)
   );

   sw_sync_debounce #(.DB_CYC(DB_CYC)) u_rst_sw (
      .clk    (clk),
      .resetn (resetn),
      .sw     (sw_rst_req),
      .rise   (rst_rise)
   );

   // With both pending, alternate away from whatever was served last.
   assign grant   = (state == ST_IDLE) && (set_pend || rst_pend);
   assign gnt_sel = (set_pend && rst_pend) ? ~last_grant : rst_pend;
   assign op_nxt  = grant ? gnt_sel : last_grant;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (grant) state_nxt = ST_SETUP;
         ST_SETUP: if (phase == 4'(SETUP_CYC - 1)) state_nxt = ST_PULSE;
         ST_PULSE: if (phase == 4'(PULSE_CYC - 1)) state_nxt = ST_HOLD;
         ST_HOLD:  state_nxt = ST_CHECK;
         ST_CHECK: state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   assign drive_nxt = (state_nxt == ST_SETUP) || (state_nxt == ST_PULSE) ||
                      (state_nxt == ST_HOLD);

   // Outputs are registered from the next state so the latch sees glitch-free lines.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= ST_IDLE;
         phase      <= '0;
         set_pend   <= 1'b0;
         rst_pend   <= 1'b0;
         last_grant <= 1'b0;
         led_err    <= 1'b0;
         latch_clk  <= 1'b0;
         latch_s    <= 1'b0;
         latch_r    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state    <= state_nxt;
         phase    <= (state_nxt != state) ? 4'd0 : phase + 4'd1;
         set_pend <= set_rise | (set_pend & ~(grant && gnt_sel == GRANT_SET));
         rst_pend <= rst_rise | (rst_pend & ~(grant && gnt_sel == GRANT_RST));
         if (grant)
            last_grant <= gnt_sel;
         if (state == ST_CHECK)
            led_err <= (latch_q != (last_grant == GRANT_SET));
         latch_clk <= (state_nxt == ST_PULSE);
         latch_s   <= drive_nxt && (op_nxt == GRANT_SET);
         latch_r   <= drive_nxt && (op_nxt == GRANT_RST);
         busy      <= (state_nxt != ST_IDLE);
      end
   end

endmodule

// File: tb/tb_rs_latch_sequencer.sv
// Directed bench for rs_latch_sequencer with a behavioural RS latch model.
module tb_rs_latch_sequencer;

   logic clk = 1'b0;
   logic resetn;
   logic sw_set_req;
   logic sw_rst_req;
   logic latch_q = 1'b0;
   logic latch_clk;
   logic latch_s;
   logic latch_r;
   logic busy;
   logic last_grant;
   logic led_err;
   logic stuck;

   int checks = 0;
   int failures = 0;
   int s_cnt, r_cnt, c_cnt, b_cnt, both_cnt;

   always #5 clk = ~clk;

   rs_latch_sequencer dut (
      .clk        (clk),
      .resetn     (resetn),
      .sw_set_req (sw_set_req),
      .sw_rst_req (sw_rst_req),
      .latch_q    (latch_q),
      .latch_clk  (latch_clk),
      .latch_s    (latch_s),
      .latch_r    (latch_r),
      .busy       (busy),
      .last_grant (last_grant),
      .led_err    (led_err)
   );

   // Level-triggered RS latch; 'stuck' forces Q low to model a broken part.
   always @(posedge clk) begin
      if (stuck)
         latch_q <= 1'b0;
      else if (latch_clk) begin
         if (latch_s)
            latch_q <= 1'b1;
         else if (latch_r)
            latch_q <= 1'b0;
      end
   end

   task automatic clr();
      s_cnt = 0; r_cnt = 0; c_cnt = 0; b_cnt = 0; both_cnt = 0;
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (latch_s) s_cnt++;
         if (latch_r) r_cnt++;
         if (latch_clk) c_cnt++;
         if (busy) b_cnt++;
         if (latch_s && latch_r) both_cnt++;
      end
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      resetn = 1'b0; sw_set_req = 1'b0; sw_rst_req = 1'b0; stuck = 1'b0;
      clr();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_clk", int'(latch_clk), 0);
      chk("rst_s", int'(latch_s), 0);
      chk("rst_r", int'(latch_r), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_last_grant", int'(last_grant), 0);
      chk("rst_led_err", int'(led_err), 0);
      resetn = 1'b1;
      tick(4);

`ifdef RS_SEQ_DEBOUNCE_EN
      // 5-cycle glitch must be filtered.
      clr();
      sw_set_req = 1'b1; tick(5);
      sw_set_req = 1'b0; tick(30);
      chk("db_glitch_busy_cycles", b_cnt, 0);
      // Clean rise: pending at +19, SETUP at +20.
      sw_set_req = 1'b1;
      tick(19);
      chk("db_busy_at19", int'(busy), 0);
      tick(1);
      chk("db_busy_at20", int'(busy), 1);
      chk("db_s_at20", int'(latch_s), 1);
      tick(10);
      chk("db_done_busy", int'(busy), 0);
      chk("db_led_err", int'(led_err), 0);
`else
      // Single set op: pending at +3, SETUP at +4, IDLE at +11.
      clr();
      sw_set_req = 1'b1;
      tick(3);
      chk("t1_busy_at3", int'(busy), 0);
      tick(1);
      chk("t1_busy_at4", int'(busy), 1);
      chk("t1_s_setup", int'(latch_s), 1);
      chk("t1_clk_setup", int'(latch_clk), 0);
      tick(6);
      chk("t1_s_check", int'(latch_s), 0);
      chk("t1_busy_check", int'(busy), 1);
      tick(1);
      chk("t1_busy_idle", int'(busy), 0);
      chk("t1_s_cycles", s_cnt, 6);
      chk("t1_clk_cycles", c_cnt, 4);
      chk("t1_r_cycles", r_cnt, 0);
      chk("t1_led_err", int'(led_err), 0);
      chk("t1_last_grant", int'(last_grant), 0);
      sw_set_req = 1'b0;
      tick(4);

      // Both at once with last_grant=0: reset first, then set after one IDLE.
      clr();
      sw_set_req = 1'b1; sw_rst_req = 1'b1;
      tick(4);
      chk("t2_r_first", int'(latch_r), 1);
      chk("t2_s_first", int'(latch_s), 0);
      chk("t2_lg_first", int'(last_grant), 1);
      tick(7);
      chk("t2_idle_gap", int'(busy), 0);
      tick(1);
      chk("t2_s_second", int'(latch_s), 1);
      chk("t2_lg_second", int'(last_grant), 0);
      tick(7);
      chk("t2_busy_done", int'(busy), 0);
      chk("t2_r_cycles", r_cnt, 6);
      chk("t2_s_cycles", s_cnt, 6);
      chk("t2_both_high", both_cnt, 0);
      chk("t2_led_err", int'(led_err), 0);
      sw_set_req = 1'b0; sw_rst_req = 1'b0;
      tick(4);

      // Q stuck low: set fails, then reset matches and clears the error.
      stuck = 1'b1;
      sw_set_req = 1'b1;
      tick(11);
      chk("t3_busy", int'(busy), 0);
      chk("t3_err_set", int'(led_err), 1);
      sw_set_req = 1'b0;
      tick(4);
      sw_rst_req = 1'b1;
      tick(11);
      chk("t3_err_rst", int'(led_err), 0);
      chk("t3_lg", int'(last_grant), 1);
      sw_rst_req = 1'b0; stuck = 1'b0;
      tick(4);

      // Three set edges during one op merge into exactly one further op.
      clr();
      sw_set_req = 1'b1; tick(3);
      sw_set_req = 1'b0; tick(1);
      sw_set_req = 1'b1; tick(1);
      sw_set_req = 1'b0; tick(1);
      sw_set_req = 1'b1; tick(1);
      sw_set_req = 1'b0; tick(1);
      sw_set_req = 1'b1; tick(32);
      chk("t4_busy_cycles", b_cnt, 14);
      chk("t4_s_cycles", s_cnt, 12);
      chk("t4_busy_end", int'(busy), 0);
      sw_set_req = 1'b0;
      tick(4);

      // Reset in the 2nd PULSE cycle; switch stays high across release.
      sw_set_req = 1'b1;
      tick(6);
      chk("t5_clk_pulse2", int'(latch_clk), 1);
      #2 resetn = 1'b0;
      #1;
      chk("t5_clk_async", int'(latch_clk), 0);
      chk("t5_s_async", int'(latch_s), 0);
      chk("t5_r_async", int'(latch_r), 0);
      chk("t5_busy_async", int'(busy), 0);
      tick(2);
      resetn = 1'b1;
      clr();
      tick(20);
      chk("t5_no_resume", b_cnt, 0);
      sw_set_req = 1'b0; tick(4);
      sw_set_req = 1'b1; tick(4);
      chk("t5_rearmed", int'(busy), 1);
      tick(10);
      sw_set_req = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
